// File: rtl/rsa_word_port.sv
// rsa_word_port
//   Word-serial front end for a wide modular exponentiation core. Operand
//   words arrive least-significant first and are assembled into full-width
//   registers; the core is then kicked with a one-cycle start, and its
//   full-width result is streamed back out least-significant word first.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-low
//   start_in       one-cycle request opening a transaction (IDLE only)
//   valid_in       qualifies one word on x / y / m / r_c (LOAD only)
//   x, y, m, r_c   operand words, LS word first
//   bit_size       exponent bit count, sampled with start_in
//   s, valid_out   result word stream, s forced to 0 while valid_out=0
//   core_x/y/m/r_c assembled operands to the core (registered)
//   core_bit_size  latched bit_size
//   core_start     one-cycle start pulse to the core
//   core_done      core completion strobe (WAIT only)
//   core_result    core result, valid while core_done=1
//   busy           high in every state except IDLE
//
// state  | meaning
// IDLE   | waiting for start_in
// LOAD   | accepting operand words, counter = next word index
// START  | core_start asserted for this single cycle
// WAIT   | waiting for core_done
// UNLOAD | driving result word <counter> on s
module rsa_word_port #(
  parameter int MONTGOMERY_MODULE_KEY_LENGTH = 512,
  parameter int WORD_WIDTH                   = 16
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    start_in,
  input  logic                                    valid_in,
  input  logic [WORD_WIDTH-1:0]                   x,
  input  logic [WORD_WIDTH-1:0]                   y,
  input  logic [WORD_WIDTH-1:0]                   m,
  input  logic [WORD_WIDTH-1:0]                   r_c,
  input  logic [15:0]                             bit_size,
  output logic [WORD_WIDTH-1:0]                   s,
  output logic                                    valid_out,
  output logic [MONTGOMERY_MODULE_KEY_LENGTH-1:0] core_x,
  output logic [MONTGOMERY_MODULE_KEY_LENGTH-1:0] core_y,
  output logic [MONTGOMERY_MODULE_KEY_LENGTH-1:0] core_m,
  output logic [MONTGOMERY_MODULE_KEY_LENGTH-1:0] core_r_c,
  output logic [15:0]                             core_bit_size,
  output logic                                    core_start,
  input  logic                                    core_done,
  input  logic [MONTGOMERY_MODULE_KEY_LENGTH-1:0] core_result,
  output logic                                    busy
);

  localparam int KL     = MONTGOMERY_MODULE_KEY_LENGTH;
  localparam int W      = WORD_WIDTH;
  localparam int NWORDS = KL / W;
  localparam int CW     = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, UNLOAD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KL-1:0]   core_x_q, core_x_d;
  logic [KL-1:0]   core_y_q, core_y_d;
  logic [KL-1:0]   core_m_q, core_m_d;
  logic [KL-1:0]   core_r_c_q, core_r_c_d;
  logic [15:0]     core_bit_size_q, core_bit_size_d;
  logic [KL-1:0]   res_q, res_d;
  logic [W-1:0]    s_q, s_d;
  logic            valid_out_q, valid_out_d;
  logic            core_start_q, core_start_d;
  logic            busy_q, busy_d;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    core_x_d        = core_x_q;
    core_y_d        = core_y_q;
    core_m_d        = core_m_q;
    core_r_c_d      = core_r_c_q;
    core_bit_size_d = core_bit_size_q;
    res_d           = res_q;
    s_d             = '0;
    valid_out_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // valid_in in the same cycle as start_in is deliberately dropped
        if (start_in) begin
          core_x_d        = '0;
          core_y_d        = '0;
          core_m_d        = '0;
          core_r_c_d      = '0;
          core_bit_size_d = bit_size;
          cnt_d           = '0;
          state_d         = LOAD;
        end
      end
      LOAD: begin
        if (valid_in) begin
          core_x_d[cnt_q*W +: W]   = x;
          core_y_d[cnt_q*W +: W]   = y;
          core_m_d[cnt_q*W +: W]   = m;
          core_r_c_d[cnt_q*W +: W] = r_c;
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      START: begin
        state_d = WAIT;
      end
      WAIT: begin
        // Word 0 goes straight to s; the shift register keeps the rest so
        // UNLOAD only ever looks at its bottom word.
        if (core_done) begin
          s_d         = core_result[W-1:0];
          res_d       = core_result >> W;
          valid_out_d = 1'b1;
          cnt_d       = '0;
          state_d     = UNLOAD;
        end
      end
      UNLOAD: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          s_d         = res_q[W-1:0];
          res_d       = res_q >> W;
          valid_out_d = 1'b1;
          cnt_d       = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    core_start_d = (state_d == START);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      core_x_q        <= '0;
      core_y_q        <= '0;
      core_m_q        <= '0;
      core_r_c_q      <= '0;
      core_bit_size_q <= '0;
      res_q           <= '0;
      s_q             <= '0;
      valid_out_q     <= 1'b0;
      core_start_q    <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      core_x_q        <= core_x_d;
      core_y_q        <= core_y_d;
      core_m_q        <= core_m_d;
      core_r_c_q      <= core_r_c_d;
      core_bit_size_q <= core_bit_size_d;
      res_q           <= res_d;
      s_q             <= s_d;
      valid_out_q     <= valid_out_d;
      core_start_q    <= core_start_d;
      busy_q          <= busy_d;
    end
  end

  assign s             = s_q;
  assign valid_out     = valid_out_q;
  assign core_x        = core_x_q;
  assign core_y        = core_y_q;
  assign core_m        = core_m_q;
  assign core_r_c      = core_r_c_q;
  assign core_bit_size = core_bit_size_q;
  assign core_start    = core_start_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_rsa_word_port.sv
// tb_rsa_word_port
//   Directed bench for rsa_word_port at default parameters: table of whole
//   transactions plus hand sequences for stray starts, early core_done and
//   reset in the middle of LOAD and UNLOAD.
module tb_rsa_word_port;
  localparam int KL = 512;
  localparam int W  = 16;
  localparam int N  = KL / W;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_in = 1'b0;
  logic          valid_in = 1'b0;
  logic [W-1:0]  x = '0, y = '0, m = '0, r_c = '0;
  logic [15:0]   bit_size = '0;
  logic [W-1:0]  s;
  logic          valid_out;
  logic [KL-1:0] core_x, core_y, core_m, core_r_c;
  logic [15:0]   core_bit_size;
  logic          core_start;
  logic          core_done = 1'b0;
  logic [KL-1:0] core_result = '0;
  logic          busy;

  int n_checks = 0;
  int n_err    = 0;
  int start_pulses = 0;

  rsa_word_port #(.MONTGOMERY_MODULE_KEY_LENGTH(KL), .WORD_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .valid_in(valid_in),
    .x(x), .y(y), .m(m), .r_c(r_c), .bit_size(bit_size),
    .s(s), .valid_out(valid_out),
    .core_x(core_x), .core_y(core_y), .core_m(core_m), .core_r_c(core_r_c),
    .core_bit_size(core_bit_size), .core_start(core_start),
    .core_done(core_done), .core_result(core_result), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (core_start) start_pulses <= start_pulses + 1;

  typedef struct {
    logic [15:0]   bs;
    int            gap;
    logic [15:0]   xb, yb, mw, rcw;
    logic [KL-1:0] res;
    logic [15:0]   exp_x0, exp_x31, exp_y1, exp_s0, exp_s31;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [KL-1:0] act, input logic [KL-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // word k = base + k (mod 2^16)
  function automatic logic [KL-1:0] ramp(input logic [15:0] base);
    logic [KL-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = base + 16'(k);
    return v;
  endfunction

  function automatic logic [KL-1:0] fill(input logic [15:0] w);
    logic [KL-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[k*W +: W] = w;
    return v;
  endfunction

  // Leaves the DUT in START right after the last beat's edge.
  task automatic do_load(input logic [15:0] bs, input int gap, input logic [15:0] xb, yb,
                         input logic [15:0] mw, rcw, input bit dirty, input int stray_after);
    start_in = 1'b1; bit_size = bs; valid_in = dirty; x = 16'hDEAD; y = 16'hDEAD;
    m = 16'hDEAD; r_c = 16'hDEAD;
    tick();
    start_in = 1'b0; valid_in = 1'b0;
    check("busy_after_start", busy, 1);
    for (int k = 0; k < N; k++) begin
      valid_in = 1'b1; x = xb + 16'(k); y = yb + 16'(k); m = mw; r_c = rcw;
      tick();
      valid_in = 1'b0;
      if (k == N - 1) begin
        check("core_start_after_last_beat", core_start, 1);
      end else begin
        if (core_start) check("core_start_early", core_start, 0);
        if (gap > 0 && (k % 4) == 3) repeat (gap) tick();
        if (k == stray_after) begin
          start_in = 1'b1; bit_size = 16'h0BAD;
          tick();
          start_in = 1'b0;
        end
      end
    end
  endtask

  task automatic do_unload(input logic [KL-1:0] res, input logic [15:0] exp_s0, exp_s31);
    logic [KL-1:0] r;
    r = res;
    repeat (3) tick();
    check("wait_no_valid", valid_out, 0);
    check("wait_busy", busy, 1);
    core_done = 1'b1; core_result = res;
    tick();
    core_done = 1'b0; core_result = '0;
    for (int j = 0; j < N; j++) begin
      check("unload_valid", valid_out, 1);
      check("unload_s", s, r[j*W +: W]);
      if (j == 0)     check("unload_s_first", s, exp_s0);
      if (j == N - 1) check("unload_s_last", s, exp_s31);
      tick();
    end
    check("end_valid_out", valid_out, 0);
    check("end_s", s, 0);
    check("end_busy", busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int p0;
    p0 = start_pulses;
    do_load(v.bs, v.gap, v.xb, v.yb, v.mw, v.rcw, 1'b0, -1);
    tick();
    check("core_start_one_cycle", core_start, 0);
    check("core_x", core_x, ramp(v.xb));
    check("core_y", core_y, ramp(v.yb));
    check("core_m", core_m, fill(v.mw));
    check("core_r_c", core_r_c, fill(v.rcw));
    check("core_x_w0", core_x[15:0], v.exp_x0);
    check("core_x_w31", core_x[511:496], v.exp_x31);
    check("core_y_w1", core_y[31:16], v.exp_y1);
    check("core_bit_size", core_bit_size, v.bs);
    do_unload(v.res, v.exp_s0, v.exp_s31);
    check("core_x_held", core_x, ramp(v.xb));
    check("core_bit_size_held", core_bit_size, v.bs);
    check("start_pulse_count", start_pulses - p0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid_out"}, valid_out, 0);
    check({tag, "_s"}, s, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_core_x"}, core_x, 0);
    check({tag, "_core_y"}, core_y, 0);
    check({tag, "_core_m"}, core_m, 0);
    check({tag, "_core_r_c"}, core_r_c, 0);
    check({tag, "_core_bit_size"}, core_bit_size, 0);
  endtask

  initial begin
    logic [KL-1:0] res_b;
    int p0;

    vecs[0] = '{bs: 16'd512, gap: 0, xb: 16'h0000, yb: 16'h1000, mw: 16'hFFFF, rcw: 16'hA5A5,
                res: 512'h1, exp_x0: 16'h0000, exp_x31: 16'h001F, exp_y1: 16'h1001,
                exp_s0: 16'h0001, exp_s31: 16'h0000};
    vecs[1] = '{bs: 16'd512, gap: 3, xb: 16'h0000, yb: 16'h1000, mw: 16'hFFFF, rcw: 16'hA5A5,
                res: 512'h1, exp_x0: 16'h0000, exp_x31: 16'h001F, exp_y1: 16'h1001,
                exp_s0: 16'h0001, exp_s31: 16'h0000};
    vecs[2] = '{bs: 16'h0100, gap: 1, xb: 16'h8000, yb: 16'hFFF0, mw: 16'h1234, rcw: 16'h0000,
                res: {16'hBEEF, 480'h0, 16'hCAFE}, exp_x0: 16'h8000, exp_x31: 16'h801F,
                exp_y1: 16'hFFF1, exp_s0: 16'hCAFE, exp_s31: 16'hBEEF};
    vecs[3] = '{bs: 16'hFFFF, gap: 2, xb: 16'hFFFF, yb: 16'h0000, mw: 16'h0000, rcw: 16'hFFFF,
                res: {KL{1'b1}}, exp_x0: 16'hFFFF, exp_x31: 16'h001E, exp_y1: 16'h0001,
                exp_s0: 16'hFFFF, exp_s31: 16'hFFFF};

    // reset state
    rst = 1'b0;
    tick(); tick();
    rst = 1'b1;
    check_all_zero("reset");

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // start_in with valid_in in IDLE, stray start in LOAD after beat 10,
    // core_done during START and stray start during WAIT
    p0 = start_pulses;
    do_load(16'h0200, 0, 16'h0100, 16'h2000, 16'h5555, 16'h3C3C, 1'b1, 10);
    core_done = 1'b1; core_result = {KL{1'b1}};
    tick();
    core_done = 1'b0; core_result = '0;
    check("done_in_start_ignored", valid_out, 0);
    check("seq_x_word0", core_x[15:0], 16'h0100);
    check("seq_x_word31", core_x[511:496], 16'h011F);
    check("seq_core_x", core_x, ramp(16'h0100));
    check("seq_bit_size", core_bit_size, 16'h0200);
    start_in = 1'b1; bit_size = 16'h0BAD;
    tick();
    start_in = 1'b0;
    check("wait_start_ignored_busy", busy, 1);
    check("wait_start_no_core_start", core_start, 0);
    res_b = {16'h1111, 464'h0, 16'h3333, 16'h2222};
    do_unload(res_b, 16'h2222, 16'h1111);
    check("seq_start_pulses", start_pulses - p0, 1);

    // reset mid-LOAD, then a normal transaction
    start_in = 1'b1; bit_size = 16'd64;
    tick();
    start_in = 1'b0;
    for (int k = 0; k < 7; k++) begin
      valid_in = 1'b1; x = 16'h7700 + 16'(k);
      tick();
    end
    valid_in = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_all_zero("rst_load");
    run_vec(vecs[0]);

    // reset during UNLOAD word 5, then a normal transaction
    do_load(16'd512, 0, 16'h4000, 16'h5000, 16'h6000, 16'h7000, 1'b0, -1);
    tick();
    res_b = '0;
    for (int j = 0; j < N; j++) res_b[j*W +: W] = 16'hA000 + 16'(j);
    core_done = 1'b1; core_result = res_b;
    tick();
    core_done = 1'b0; core_result = '0;
    repeat (5) tick();
    check("pre_rst_word5", s, 16'hA005);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_all_zero("rst_unload");
    run_vec(vecs[2]);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
